cic_decimator_core: RTL and testbench
=====================================

# cic_decimator_core

Multi-stage cascaded integrator-comb (CIC) decimation filter for the SDR receive datapath. It sits between the DDC mixer output and the channel FIR. It accepts one signed sample per qualified clock and emits one gain-compensated signed sample every DECIMATION accepted inputs. The unit-DC-gain output lets downstream blocks treat its output as full-scale data.

## Interface
- INPUT_WIDTH, 32: input sample width, signed two's complement.
- OUTPUT_WIDTH, 32: output sample width, signed two's complement.
- STAGES, 3: number of integrator stages and number of comb stages (N). Legal range is 1..6.
- DECIMATION, 8: rate change R. Must be a power of two, 2..64. Differential delay M = 1.
- clk, input, 1: system clock (100 MHz).
- rst, input, 1: reset. Asynchronous, active-high.
- data_in, input, INPUT_WIDTH: input sample, signed.
- data_valid, input, 1: qualifies data_in on the current rising edge.
- data_out, output, OUTPUT_WIDTH: decimated sample, signed. Held between strobes.
- output_valid, output, 1: single-cycle strobe marking a new data_out.

## Operation
- ACC_WIDTH = INPUT_WIDTH + STAGES·log2(DECIMATION). With defaults this is 41. All integrator and comb registers are ACC_WIDTH bits.
- Integrators:
  - On each edge with data_valid=1: I1 ← I1 + sext(data_in), then Ik ← Ik + I(k−1) using the old registered value.
  - Arithmetic is modular (wrap-around). Overflow is intended and must not be saturated.
- With data_valid=0, all integrator, counter and comb state holds.
- Phase counter counts accepted samples 0..DECIMATION−1 and wraps. The accept with counter = DECIMATION−1 raises the decimation strobe.
- Combs run only on decimated strobes:
  - C1 = IN − IN_prev.
  - Ck = C(k−1) − C(k−1)_prev.
  - Arithmetic is modular ACC_WIDTH.
- Gain compensation:
  - result = CN arithmetic-shifted right by SHIFT = STAGES·log2(DECIMATION), giving an exact divide by R^N.
  - Truncation toward −∞ (unless rounding is enabled, see Configuration).
  - Sign-extend or clamp to OUTPUT_WIDTH: if the value exceeds the signed OUTPUT_WIDTH range, saturate to max/min.
- DC gain is exactly 1. A settled constant input x produces data_out = x.

## Timing
- Reset values: data_out = 0, output_valid = 0. All integrators, combs, delay registers and the phase counter are 0.
- Reset asserted mid-operation clears everything immediately and discards any in-flight output. The first output after reset requires DECIMATION fresh accepts.
- Latency: output_valid rises exactly STAGES+2 clocks after the edge that accepts the DECIMATION-th sample of a group.
  - 1 clock for the integrator tap.
  - STAGES clocks for the pipelined combs.
  - 1 clock for the output register.
- output_valid is high for exactly one clock per decimated sample.
- Gaps in data_valid only stretch the group; latency is counted from the last accept.
- Maximum throughput is one input per clock. The comb pipeline never stalls, so back-to-back groups are legal.

## Configuration
- CIC_ROUND_EN defined: add 2^(SHIFT−1) to CN before the shift, giving round-half-up.
- CIC_ROUND_EN undefined: plain truncation.
- Both settings give identical results for exact multiples of R^N.

## Structure
- Package cic_pkg holds:
  - function clog2.
  - function acc_width(INPUT_WIDTH, STAGES, DECIMATION).
  - function shift_amt(STAGES, DECIMATION).
  - signed saturation helper sat_to_width.
- Sub-module cic_comb_stage: one registered differentiator with enable, instantiated STAGES times in a generate loop.
- Integrators, phase counter and output scaling stay in the top module.

## Test plan
- Reset: hold rst=1 for 10 cycles with random data_in/data_valid → data_out=0 and output_valid=0 throughout.
- DC positive: 64 consecutive valid samples of 0x00010000 → 8 strobes. The 4th strobe onward gives data_out=0x00010000. Each strobe is exactly STAGES+2=5 clocks after its 8th accept.
- DC negative and small: constant 0xFFFF0000 (−65536), then constant 3 → settled outputs 0xFFFF0000 and 0x00000003, in both CIC_ROUND_EN builds.
- Impulse: one sample 0x00010000 followed by zeros for 64 accepts → outputs are non-negative and return to exactly 0 by the 4th strobe. The sum of all outputs must match the Python model bit-exactly.
- Throttled input: DC 0x00010000 with data_valid toggling 1-0-1-0 → strobe rate halves. Settled value is unchanged, and latency is still 5 clocks after the last accept.
- Reset mid-group: assert rst after 5 accepts, release, feed 8 accepts of 0 → exactly one strobe, with data_out=0.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared sizing helpers and the signed saturation function for the CIC decimator.
package cic_pkg;

    localparam int SAT_WIDTH = 128;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int acc_width(input int input_width, input int stages, input int decimation);
        return input_width + stages * clog2(decimation);
    endfunction

    function automatic int shift_amt(input int stages, input int decimation);
        return stages * clog2(decimation);
    endfunction

    // Clamp a wide signed value into the signed range of 'width' bits; caller truncates.
    function automatic logic signed [SAT_WIDTH-1:0] sat_to_width(
        input logic signed [SAT_WIDTH-1:0] value,
        input int width
    );
        logic signed [SAT_WIDTH-1:0] max_val;
        logic signed [SAT_WIDTH-1:0] min_val;
        max_val = (128'sd1 <<< (width - 1)) - 128'sd1;
        min_val = -max_val - 128'sd1;
        if (value > max_val) return max_val;
        if (value < min_val) return min_val;
        return value;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator (M = 1); advances only when enabled.
module cic_comb_stage #(
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= enable;
            if (enable) begin
                data_out <= data_in - prev;
                prev     <= data_in;
            end
        end
    end

endmodule

// File: rtl/cic_decimator_core.sv
// N-stage CIC decimator with exact 1/R^N gain compensation and output saturation.
// Optional macro CIC_ROUND_EN: round-half-up before the compensating shift (default truncates).
module cic_decimator_core
    import cic_pkg::*;
#(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 32,
    parameter int STAGES       = 3,
    parameter int DECIMATION   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  data_in,
    input  logic                    data_valid,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic                    output_valid
);

    localparam int ACC_WIDTH   = acc_width(INPUT_WIDTH, STAGES, DECIMATION);
    localparam int SHIFT       = shift_amt(STAGES, DECIMATION);
    localparam int PHASE_WIDTH = clog2(DECIMATION);
    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(DECIMATION - 1);

    logic [ACC_WIDTH-1:0]   integ [STAGES];
    logic [ACC_WIDTH-1:0]   in_ext;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   dec_strobe;
    logic [ACC_WIDTH-1:0]   tap;
    logic                   tap_valid;
    logic [ACC_WIDTH-1:0]   comb_data [STAGES+1];
    logic [STAGES:0]        comb_valid;

    logic signed [ACC_WIDTH-1:0] biased;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic signed [SAT_WIDTH-1:0] scaled_wide;

    assign in_ext = {{(ACC_WIDTH - INPUT_WIDTH){data_in[INPUT_WIDTH-1]}}, data_in};

    // Pipelined integrators: each stage adds the previous stage's registered value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (data_valid) begin
            integ[0] <= integ[0] + in_ext;
            for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= '0;
            dec_strobe <= 1'b0;
        end else begin
            dec_strobe <= data_valid && (phase == LAST_PHASE);
            if (data_valid) phase <= phase + PHASE_WIDTH'(1);
        end
    end

    // Tap the last integrator one clock after the group's final accept has landed in it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap       <= '0;
            tap_valid <= 1'b0;
        end else begin
            tap_valid <= dec_strobe;
            if (dec_strobe) tap <= integ[STAGES-1];
        end
    end

    assign comb_data[0]  = tap;
    assign comb_valid[0] = tap_valid;

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        cic_comb_stage #(
            .WIDTH(ACC_WIDTH)
        ) u_comb (
            .clk      (clk),
            .rst      (rst),
            .enable   (comb_valid[g]),
            .data_in  (comb_data[g]),
            .data_out (comb_data[g+1]),
            .valid_out(comb_valid[g+1])
        );
    end

`ifdef CIC_ROUND_EN
    localparam logic [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) << (SHIFT - 1);
`endif

    always_comb begin
`ifdef CIC_ROUND_EN
        biased = comb_data[STAGES] + ROUND_BIAS;
`else
        biased = comb_data[STAGES];
`endif
        scaled      = biased >>> SHIFT;
        scaled_wide = {{(SAT_WIDTH - ACC_WIDTH){scaled[ACC_WIDTH-1]}}, scaled};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out     <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= comb_valid[STAGES];
            if (comb_valid[STAGES]) data_out <= OUTPUT_WIDTH'(sat_to_width(scaled_wide, OUTPUT_WIDTH));
        end
    end

endmodule

// File: tb/tb_cic_decimator_core.sv
// Self-checking bench for cic_decimator_core: behavioural CIC model feeding a timed scoreboard.
module tb_cic_decimator_core;

    localparam int IW  = 32;
    localparam int OW  = 32;
    localparam int N   = 3;
    localparam int R   = 8;
    localparam int AW  = 41;
    localparam int SH  = 9;
    localparam int LAT = N + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] data_in;
    logic          data_valid;
    logic [OW-1:0] data_out;
    logic          output_valid;

    cic_decimator_core #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .STAGES      (N),
        .DECIMATION  (R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_out    (data_out),
        .output_valid(output_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [OW-1:0] value;
        int            due;
    } exp_t;

    typedef struct {
        logic [IW-1:0] value;
        int            accepts;
        bit            throttle;
        logic [OW-1:0] settled;
        int            strobes;
    } vec_t;

    exp_t sbq[$];
    logic [OW-1:0] captured[$];
    int tests = 0;
    int fails = 0;

    logic signed [AW-1:0] mi [N];
    logic signed [AW-1:0] mc [N];
    int mphase;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < N; k++) begin
            mi[k] = '0;
            mc[k] = '0;
        end
        mphase = 0;
        sbq.delete();
        captured.delete();
    endtask

    // Reference CIC: integrators use old values, combs and scaling evaluated at once per group.
    task automatic modelAccept(input logic [IW-1:0] x, input int due);
        logic signed [AW-1:0] old_i [N];
        logic signed [AW-1:0] c;
        logic signed [AW-1:0] t;
        longint v;
        exp_t e;
        old_i = mi;
        mi[0] = old_i[0] + {{(AW - IW){x[IW-1]}}, x};
        for (int k = 1; k < N; k++) mi[k] = old_i[k] + old_i[k-1];
        if (mphase == R - 1) begin
            c = mi[N-1];
            for (int k = 0; k < N; k++) begin
                t = c - mc[k];
                mc[k] = c;
                c = t;
            end
`ifdef CIC_ROUND_EN
            c = c + (AW'(1) << (SH - 1));
`endif
            c = c >>> SH;
            v = c;
            if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
            if (v < -64'sh8000_0000) v = -64'sh8000_0000;
            e.value = v[OW-1:0];
            e.due   = due;
            sbq.push_back(e);
        end
        mphase = (mphase + 1) % R;
    endtask

    task automatic applyStimulus(input logic [IW-1:0] x, input logic v);
        @(negedge clk);
        data_in    = x;
        data_valid = v;
        if (v && !rst) modelAccept(x, cyc + 1 + LAT);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus($urandom, 1'b0);
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        for (int i = 0; i < cycles; i++) begin
            data_in    = $urandom;
            data_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("reset_data_out", longint'(data_out), 0);
            checkOutput("reset_output_valid", longint'(output_valid), 0);
        end
        rst        = 1'b0;
        data_valid = 1'b0;
        captured.delete();
    endtask

    // Scoreboard monitor: flags missed, spurious, mistimed or wrong strobes.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            checkOutput("missed_strobe", cyc, sbq[0].due);
            void'(sbq.pop_front());
        end
        if (output_valid) begin
            if (sbq.size() == 0) begin
                checkOutput("spurious_strobe", 0, 1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("strobe_data", longint'($signed(data_out)), longint'($signed(e.value)));
                checkOutput("strobe_latency", cyc, e.due);
            end
            captured.push_back(data_out);
        end
    end

    vec_t vecs [5];
    int   imp_expect [8];
    longint sum;

    initial begin
        rst        = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        modelReset();

        vecs[0] = '{32'h0001_0000, 64, 1'b0, 32'h0001_0000, 8};
        vecs[1] = '{32'hFFFF_0000, 64, 1'b0, 32'hFFFF_0000, 8};
        vecs[2] = '{32'h0000_0003, 64, 1'b0, 32'h0000_0003, 8};
        vecs[3] = '{32'h0001_0000, 32, 1'b1, 32'h0001_0000, 4};
        vecs[4] = '{32'h8000_0000, 40, 1'b0, 32'h8000_0000, 5};

        imp_expect = '{2688, 5376, 128, 0, 0, 0, 0, 0};

        doReset(10);

        for (int v = 0; v < 5; v++) begin
            doReset(2);
            for (int i = 0; i < vecs[v].accepts; i++) begin
                applyStimulus(vecs[v].value, 1'b1);
                if (vecs[v].throttle) applyStimulus(vecs[v].value, 1'b0);
            end
            idle(LAT + 4);
            checkOutput("dc_strobe_count", captured.size(), vecs[v].strobes);
            for (int s = 3; s < captured.size(); s++)
                checkOutput("dc_settled", longint'($signed(captured[s])), longint'($signed(vecs[v].settled)));
            checkOutput("dc_held", longint'($signed(data_out)), longint'($signed(vecs[v].settled)));
        end

        doReset(2);
        applyStimulus(32'h0001_0000, 1'b1);
        for (int i = 1; i < 64; i++) applyStimulus('0, 1'b1);
        idle(LAT + 4);
        checkOutput("impulse_strobe_count", captured.size(), 8);
        sum = 0;
        for (int s = 0; s < captured.size() && s < 8; s++) begin
            checkOutput("impulse_value", longint'($signed(captured[s])), imp_expect[s]);
            sum += longint'($signed(captured[s]));
        end
        checkOutput("impulse_sum", sum, 8192);

        doReset(2);
        for (int i = 0; i < R; i++) applyStimulus(32'h0001_0000, 1'b1);
        idle(2);
        doReset(1);
        idle(LAT + 4);
        checkOutput("inflight_discarded", captured.size(), 0);

        doReset(2);
        for (int i = 0; i < 5; i++) applyStimulus(32'h0001_0000, 1'b1);
        doReset(2);
        for (int i = 0; i < R; i++) applyStimulus('0, 1'b1);
        idle(LAT + 4);
        checkOutput("midgroup_strobe_count", captured.size(), 1);
        if (captured.size() > 0) checkOutput("midgroup_data", longint'($signed(captured[0])), 0);

        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
